alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Two-stage pipelined decode/issue and writeback block that drives the team's 32-bit ALU and consumes its outputs. Stage 1 registers a RISC-V instruction plus operands, decodes the ALU control code, selects operands and drives them to the ALU. Stage 2 captures the ALU result and zero flag and resolves branch direction and target. The block uses a valid/ready handshake on both ends and sustains one instruction per cycle.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous pipeline kill
in_valid  in  1  upstream instruction valid
in_ready  out  1  block accepts the instruction this cycle
in_instr  in  32  instruction word
in_pc  in  32  instruction PC
in_rs1  in  32  rs1 register value
in_rs2  in  32  rs2 register value
alu_a  out  32  ALU operand a (stage-1 register)
alu_b  out  32  ALU operand b (stage-1 register)
alu_ctrl  out  4  ALU op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
alu_result  in  32  combinational ALU result
alu_zero  in  1  ALU zero flag
out_valid  out  1  stage-2 result valid
out_ready  in  1  downstream accepts
out_result  out  32  captured ALU result
out_is_branch  out  1  instruction was a conditional branch
out_taken  out  1  branch resolved taken
out_target  out  32  in_pc + B-immediate (valid when out_is_branch)
out_illegal  out  1  opcode/funct combination not supported

Behaviour:
- Reset (rst=1 at an edge): s1_valid=0, s2_valid=0, and every registered output = 0 (alu_a, alu_b, alu_ctrl, out_*). in_ready=0 while rst=1. Reset overrides flush and in_valid.
- Handshake: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv & !rst & !flush. Transfer occurs when in_valid & in_ready. Outputs hold stable while out_valid & !out_ready.
- Latency: an instruction accepted at edge N appears at alu_a/b/ctrl after edge N and at out_* with out_valid=1 after edge N+1. Throughput is 1/cycle with out_ready held high.
- Stage 2 captures alu_result/alu_zero only on the edge where s1_valid & s2_adv. The ALU is combinational from the stage-1 registers.
- flush=1: s1_valid and s2_valid are cleared at that edge; no instruction is accepted that cycle (flush wins over in_valid).
- Decode on opcode in_instr[6:0]:
  - 0110011 R-type: a=rs1, b=rs2. f3 000 gives ADD (f7=0000000) or SUB (f7=0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (f7=0) or SRA (f7=0100000); 110 OR; 111 AND. Any other f7 is illegal.
  - 0010011 I-type: a=rs1, b=sext(instr[31:20]). Same f3 map, no SUB. For f3 001/101, instr[31:25] must be 0000000 (SLLI/SRLI) or 0100000 (SRAI, f3=101 only), else illegal.
  - 0000011 load: ADD, b=sext I-imm. 0100011 store: ADD, b=sext {instr[31:25],instr[11:7]}.
  - 1100011 branch: a=rs1, b=rs2. f3 000/001 use SUB; 100/101 use SLT; 110/111 use SLTU; 010/011 are illegal. is_branch=1. target = pc + sext{instr[31],instr[7],instr[30:25],instr[11:8],0}, computed in stage 1 with a dedicated adder, mod 2^32.
  - Any other opcode: illegal=1, ctrl=ADD, a=b=0, is_branch=0.
- An illegal instruction still flows through with out_valid=1 and out_taken=0.
- Branch resolution in stage 2: BEQ taken=zero; BNE !zero; BLT/BLTU result[0]; BGE/BGEU !result[0]. For non-branch instructions, taken=0.

Test Plan:
1. add x,rs1=7,rs2=5 then sub, back-to-back with out_ready=1 -> alu_ctrl 0000 then 0001; out_result 12 then 2 on consecutive cycles, out_valid continuous.
2. srai imm=4, rs1=0x80000000 -> alu_ctrl 0111, alu_b=4, out_result 0xF8000000; srai encoded with instr[31:25]=0000001 -> out_illegal=1.
3. beq rs1=rs2=9, pc=0x100, B-imm=-8 -> out_taken=1, out_target 0x000000F8; bltu rs1=0xFFFFFFFF, rs2=1 -> ctrl 1001, taken=0; blt with the same operands -> ctrl 1000, taken=1.
4. Backpressure: out_ready=0 for 3 cycles with 3 instructions offered -> two are held (s1 and s2 full), in_ready=0, out_* stable; releasing out_ready drains them in order, nothing lost or duplicated.
5. flush asserted with both stages full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered instruction is not accepted.
6. rst asserted mid-stream -> after the edge, all outputs 0, in_ready=0 while rst is high; opcode 0110111 afterwards -> out_illegal=1, out_result 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Two-stage issue/writeback wrapper around an external combinational 32-bit ALU.
// Stage 1 decodes and drives ALU operands; stage 2 captures the result and resolves branches.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_is_branch,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SLL = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000, ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic unused_rs1_field;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign unused_rs1_field = ^in_instr[19:15];

  // Handshake
  logic s1_valid_q, s2_valid_q, s1_adv, s2_adv, accept;
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && !rst && !flush;
  assign accept   = in_valid && in_ready;

  // Decode
  logic [XLEN-1:0] alu_a_d, alu_b_d;
  alu_op_e         alu_ctrl_d;
  logic            illegal_d, branch_d;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_ctrl_d = ALU_ADD;
    illegal_d  = 1'b0;
    branch_d   = 1'b0;
    case (opcode)
      OP_R: begin
        alu_a_d = in_rs1;
        alu_b_d = in_rs2;
        if (funct7 == 7'b0 || (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
          alu_ctrl_d = f3_to_op(funct3, funct7[5]);
        else
          illegal_d = 1'b1;
      end
      OP_I: begin
        alu_a_d = in_rs1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift-immediates carry only the 5-bit shamt; funct7 selects SRAI.
          alu_b_d = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          if (funct7 == 7'b0 || (funct3 == 3'b101 && funct7 == F7_ALT))
            alu_ctrl_d = f3_to_op(funct3, funct7[5]);
          else
            illegal_d = 1'b1;
        end else begin
          alu_b_d    = imm_i;
          alu_ctrl_d = f3_to_op(funct3, 1'b0);
        end
      end
      OP_LOAD: begin
        alu_a_d = in_rs1;
        alu_b_d = imm_i;
      end
      OP_STORE: begin
        alu_a_d = in_rs1;
        alu_b_d = imm_s;
      end
      OP_BRANCH: begin
        alu_a_d  = in_rs1;
        alu_b_d  = in_rs2;
        branch_d = 1'b1;
        case (funct3)
          3'b000, 3'b001: alu_ctrl_d = ALU_SUB;
          3'b100, 3'b101: alu_ctrl_d = ALU_SLT;
          3'b110, 3'b111: alu_ctrl_d = ALU_SLTU;
          default: begin
            illegal_d = 1'b1;
            branch_d  = 1'b0;
          end
        endcase
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Stage 1 registers
  logic [XLEN-1:0] alu_a_q, alu_b_q, s1_target_q;
  alu_op_e         alu_ctrl_q;
  logic [2:0]      s1_f3_q;
  logic            s1_illegal_q, s1_branch_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= ALU_ADD;
      s1_target_q  <= '0;
      s1_f3_q      <= '0;
      s1_illegal_q <= 1'b0;
      s1_branch_q  <= 1'b0;
    end else begin
      if (flush)       s1_valid_q <= 1'b0;
      else if (s1_adv) s1_valid_q <= in_valid;
      if (accept) begin
        alu_a_q      <= alu_a_d;
        alu_b_q      <= alu_b_d;
        alu_ctrl_q   <= alu_ctrl_d;
        s1_target_q  <= in_pc + imm_b;
        s1_f3_q      <= funct3;
        s1_illegal_q <= illegal_d;
        s1_branch_q  <= branch_d;
      end
    end
  end

  // Branch resolution from the live ALU outputs
  logic out_taken_d;
  always_comb begin
    out_taken_d = 1'b0;
    if (s1_branch_q) begin
      case (s1_f3_q)
        3'b000:         out_taken_d = alu_zero;
        3'b001:         out_taken_d = !alu_zero;
        3'b100, 3'b110: out_taken_d = alu_result[0];
        3'b101, 3'b111: out_taken_d = !alu_result[0];
        default:        out_taken_d = 1'b0;
      endcase
    end
  end

  // Stage 2 registers
  logic [XLEN-1:0] out_result_q, out_target_q;
  logic            out_is_branch_q, out_taken_q, out_illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q      <= 1'b0;
      out_result_q    <= '0;
      out_target_q    <= '0;
      out_is_branch_q <= 1'b0;
      out_taken_q     <= 1'b0;
      out_illegal_q   <= 1'b0;
    end else begin
      if (flush)       s2_valid_q <= 1'b0;
      else if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s1_valid_q && s2_adv && !flush) begin
        out_result_q    <= alu_result;
        out_target_q    <= s1_target_q;
        out_is_branch_q <= s1_branch_q;
        out_taken_q     <= out_taken_d;
        out_illegal_q   <= s1_illegal_q;
      end
    end
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_ctrl      = alu_ctrl_q;
  assign out_valid     = s2_valid_q;
  assign out_result    = out_result_q;
  assign out_target    = out_target_q;
  assign out_is_branch = out_is_branch_q;
  assign out_taken     = out_taken_q;
  assign out_illegal   = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU environment, directed test-plan steps,
// then randomized traffic scored against an instruction-level reference queue.
`timescale 1ns/1ps
module tb_alu_issue_stage;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1, in_rs2, alu_a, alu_b, alu_result;
  logic [31:0] out_result, out_target;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, out_is_branch, out_taken, out_illegal;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_is_branch(out_is_branch), .out_taken(out_taken), .out_target(out_target),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;

  function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return 32'($signed(a) >>> b[4:0]);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // The ALU the block drives, modelled as the environment.
  always_comb alu_result = alu_calc(alu_ctrl, alu_a, alu_b);
  assign alu_zero = (alu_result == 32'd0);

  typedef struct packed {
    logic        illegal, ops_known, is_branch, taken;
    logic [3:0]  ctrl;
    logic [31:0] a, b, result, target;
  } exp_t;

  typedef struct packed { logic [31:0] instr, pc, rs1, rs2; } offer_t;

  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
    logic [3:0] base [8];
    base = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd7;
    return base[f3];
  endfunction

  function automatic exp_t ref_model(input offer_t o);
    exp_t e;
    logic [2:0]  f3 = o.instr[14:12];
    logic [6:0]  f7 = o.instr[31:25];
    logic [31:0] imm_i = {{20{o.instr[31]}}, o.instr[31:20]};
    logic [31:0] imm_s = {{20{o.instr[31]}}, o.instr[31:25], o.instr[11:7]};
    logic [31:0] imm_b = {{20{o.instr[31]}}, o.instr[7], o.instr[30:25], o.instr[11:8], 1'b0};
    e = '0;
    e.ops_known = 1'b1;
    case (o.instr[6:0])
      OP_R: begin
        e.a = o.rs1; e.b = o.rs2;
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) e.ctrl = f3_op(f3, f7[5]);
        else begin e.illegal = 1'b1; e.ops_known = 1'b0; end
      end
      OP_I: begin
        e.a = o.rs1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = {27'd0, o.instr[24:20]};
          if (f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)) e.ctrl = f3_op(f3, f7[5]);
          else begin e.illegal = 1'b1; e.ops_known = 1'b0; end
        end else begin
          e.b = imm_i; e.ctrl = f3_op(f3, 1'b0);
        end
      end
      OP_LOAD:  begin e.a = o.rs1; e.b = imm_i; end
      OP_STORE: begin e.a = o.rs1; e.b = imm_s; end
      OP_BRANCH: begin
        e.a = o.rs1; e.b = o.rs2; e.is_branch = 1'b1; e.target = o.pc + imm_b;
        case (f3)
          3'd0: begin e.ctrl = 4'd1; e.taken = (o.rs1 == o.rs2); end
          3'd1: begin e.ctrl = 4'd1; e.taken = (o.rs1 != o.rs2); end
          3'd4: begin e.ctrl = 4'd8; e.taken = ($signed(o.rs1) <  $signed(o.rs2)); end
          3'd5: begin e.ctrl = 4'd8; e.taken = ($signed(o.rs1) >= $signed(o.rs2)); end
          3'd6: begin e.ctrl = 4'd9; e.taken = (o.rs1 <  o.rs2); end
          3'd7: begin e.ctrl = 4'd9; e.taken = (o.rs1 >= o.rs2); end
          default: begin e.illegal = 1'b1; e.ops_known = 1'b0; e.is_branch = 1'b0; end
        endcase
      end
      default: e.illegal = 1'b1;
    endcase
    if (e.ops_known) e.result = alu_calc(e.ctrl, e.a, e.b);
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, OP_R};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] op);
    return {imm, 5'd1, f3, 5'd3, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm);
    return {imm[11:5], 5'd2, 5'd1, 3'b010, imm[4:0], OP_STORE};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  int     checks = 0;
  int     failures = 0;
  exp_t   q[$];
  offer_t offers[$];
  bit     head_fresh = 1'b0;
  bit     drive_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2);
    offer_t o;
    o = '{instr: instr, pc: pc, rs1: rs1, rs2: rs2};
    offers.push_back(o);
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic cycle();
    exp_t e;
    bit   exp_rdy, acc, exp_vld;
    if (drive_valid && offers.size() > 0) begin
      in_valid = 1'b1;
      in_instr = offers[0].instr; in_pc = offers[0].pc;
      in_rs1   = offers[0].rs1;   in_rs2 = offers[0].rs2;
    end else begin
      in_valid = 1'b0;
      in_instr = $urandom; in_pc = $urandom; in_rs1 = $urandom; in_rs2 = $urandom;
    end
    #1;
    exp_rdy = !rst && !flush && (q.size() < 2 || out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = in_valid && exp_rdy;
    e = '0;
    if (acc) e = ref_model(offers[0]);
    exp_vld = (q.size() > 0) && !head_fresh;
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
      head_fresh = 1'b0;
    end else begin
      if (exp_vld && out_ready) void'(q.pop_front());
      if (acc) begin
        head_fresh = (q.size() == 0);
        q.push_back(e);
        void'(offers.pop_front());
      end else begin
        head_fresh = 1'b0;
      end
    end
    #1;
    if (acc && e.ops_known) begin
      chk("alu_a", alu_a, e.a);
      chk("alu_b", alu_b, e.b);
      chk("alu_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
    end
    exp_vld = (q.size() > 0) && !head_fresh;
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    if (exp_vld) begin
      if (q[0].ops_known) chk("out_result", out_result, q[0].result);
      chk("out_is_branch", 32'(out_is_branch), 32'(q[0].is_branch));
      chk("out_taken", 32'(out_taken), 32'(q[0].taken));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].illegal));
      if (q[0].is_branch) chk("out_target", out_target, q[0].target);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic check_reset_zero();
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_target", out_target, 32'd0);
    chk("rst_out_flags", {28'd0, out_valid, out_is_branch, out_taken, out_illegal}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
  endtask

  function automatic offer_t rand_offer();
    offer_t o;
    logic [6:0] f7;
    logic [6:0] other_ops [4];
    other_ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h00;
      default: f7 = 7'($urandom);
    endcase
    o.pc  = $urandom & 32'hFFFF_FFFC;
    o.rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    o.rs2 = ($urandom_range(0, 3) == 0) ? o.rs1 : $urandom;
    case ($urandom_range(0, 5))
      0: o.instr = enc_r(f7, 3'($urandom));
      1: begin
        o.instr = enc_i(12'($urandom), 3'($urandom), OP_I);
        if (o.instr[13:12] == 2'b01) o.instr[31:25] = f7;
      end
      2: o.instr = enc_i(12'($urandom), 3'b010, OP_LOAD);
      3: o.instr = enc_s(12'($urandom));
      4: o.instr = enc_b(13'($urandom), 3'($urandom));
      default: o.instr = {25'($urandom), other_ops[$urandom_range(0, 3)]};
    endcase
    return o;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
    run(2);
    check_reset_zero();
    rst = 1'b0;

    // ADD then SUB back to back
    out_ready = 1'b1; drive_valid = 1'b1;
    push(enc_r(7'h00, 3'd0), 32'h0, 32'd7, 32'd5);
    push(enc_r(7'h20, 3'd0), 32'h4, 32'd7, 32'd5);
    run(4);

    // SRAI and a malformed SRAI
    push(enc_i({7'h20, 5'd4}, 3'd5, OP_I), 32'h8, 32'h8000_0000, 32'd0);
    push(enc_i({7'h01, 5'd4}, 3'd5, OP_I), 32'hC, 32'h8000_0000, 32'd0);
    run(4);

    // BEQ with negative offset, BLTU and BLT on the same operands
    push(enc_b(13'h1FF8, 3'd0), 32'h100, 32'd9, 32'd9);
    push(enc_b(13'h0010, 3'd6), 32'h200, 32'hFFFF_FFFF, 32'd1);
    push(enc_b(13'h0010, 3'd4), 32'h300, 32'hFFFF_FFFF, 32'd1);
    run(5);

    // Backpressure with three offered instructions
    out_ready = 1'b0;
    push(enc_r(7'h00, 3'd7), 32'h10, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    push(enc_i(12'hFFF, 3'd4, OP_I), 32'h14, 32'h1234_5678, 32'd0);
    push(enc_s(12'h804), 32'h18, 32'h1000, 32'd0);
    run(3);
    out_ready = 1'b1;
    run(5);

    // Flush with both stages full and a new instruction offered
    out_ready = 1'b0;
    push(enc_r(7'h00, 3'd1), 32'h20, 32'd1, 32'd31);
    push(enc_r(7'h00, 3'd3), 32'h24, 32'd3, 32'd4);
    push(enc_r(7'h00, 3'd6), 32'h28, 32'd3, 32'd4);
    run(2);
    flush = 1'b1;
    run(1);
    flush = 1'b0; out_ready = 1'b1; drive_valid = 1'b0;
    run(1);
    drive_valid = 1'b1;
    run(4);

    // Reset mid-stream, then an unsupported opcode
    push(enc_i(12'd5, 3'd0, OP_I), 32'h30, 32'd1, 32'd0);
    push(enc_i(12'd6, 3'd0, OP_I), 32'h34, 32'd1, 32'd0);
    run(2);
    rst = 1'b1;
    run(1);
    check_reset_zero();
    run(1);
    rst = 1'b0;
    offers.delete();
    push({20'hABCDE, 5'd3, 7'b0110111}, 32'h40, 32'd77, 32'd88);
    run(4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 49) == 0);
      drive_valid = ($urandom_range(0, 3) != 0);
      if (offers.size() == 0) offers.push_back(rand_offer());
      cycle();
    end
    flush = 1'b0; out_ready = 1'b1; drive_valid = 1'b0;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
